// File: rtl/matrix_result_display_pkg.sv
// Shared constants and helpers for the matrix result display: seven-segment codes,
// BCD converter states and the double-dabble step.
package matrix_disp_pkg;
    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    // Digits above 9 cannot come out of the converter; blank them rather than show garbage.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // One double-dabble iteration on {hundreds, tens, ones, binary}.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] r;
        r = s;
        for (int k = 0; k < 3; k++) begin
            if (r[8+4*k +: 4] >= 4'd5) r[8+4*k +: 4] = r[8+4*k +: 4] + 4'd3;
        end
        return {r[18:0], 1'b0};
    endfunction
endpackage

// File: rtl/matrix_result_display_if.sv
// Result words and display-side signals of the matrix result display.
interface matrix_result_display_if;
    logic [7:0] c00, c01, c10, c11;
    logic       auto_mode;
    logic [1:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;
    logic [1:0] idx;

    modport master (output c00, c01, c10, c11, auto_mode, sel,
                    input  seg, dp, an, busy, idx);
    modport slave  (input  c00, c01, c10, c11, auto_mode, sel,
                    output seg, dp, an, busy, idx);
endinterface

// File: rtl/matrix_result_display_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter; bcd only changes once a conversion is complete.
module bin_to_bcd_seq
    import matrix_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);
    bcd_state_t  state_q;
    logic [2:0]  cnt_q;
    logic [19:0] sh_q;
    logic        busy_q, done_q;
    logic [11:0] bcd_q;

    // done_q is high exactly while in DONE, so the caller can latch alongside bcd_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    sh_q    <= {12'd0, bin};
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    sh_q  <= dd_step(sh_q);
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= sh_q[19:8];
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
endmodule

// File: rtl/matrix_result_display.sv
// Shows one 2x2 result word in decimal on a scanned 4-digit display: index, hundreds, tens, ones.
module matrix_result_display
    import matrix_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int SCROLL_DIV  = 100_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_result_display_if.slave  bus
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(SCROLL_DIV);
    localparam int PW = $clog2(NUM_DIGITS);

    logic [1:0]            idx_q;
    logic [SW-1:0]         scroll_q;
    logic [RW-1:0]         ref_q;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [7:0]            mux, last_q, cap_q;
    logic                  pending_q, start, busy, done;
    logic [11:0]           bcd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            scroll_q <= '0;
        end else if (!bus.auto_mode) begin
            idx_q    <= bus.sel;
            scroll_q <= '0;
        end else if (scroll_q == SW'(SCROLL_DIV - 1)) begin
            idx_q    <= idx_q + 2'd1;
            scroll_q <= '0;
        end else begin
            scroll_q <= scroll_q + 1'b1;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    mux = bus.c00;
            2'd1:    mux = bus.c01;
            2'd2:    mux = bus.c10;
            default: mux = bus.c11;
        endcase
    end

    // A change seen while the converter is busy is picked up again once it is back in IDLE.
    assign start = pending_q || (mux != last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b1;
            last_q    <= '0;
            cap_q     <= '0;
        end else begin
            if (start && !busy) cap_q <= mux;
            if (done) begin
                last_q    <= cap_q;
                pending_q <= 1'b0;
            end
        end
    end

    bin_to_bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (mux),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // Content for the digit about to be selected; loaded together with its anode.
    always_comb begin
        ptr_d = ptr_q + 1'b1;
        an_d  = ~(NUM_DIGITS'(1) << ptr_d);
        dp_d  = 1'b1;
        case (ptr_d)
            2'd0:    seg_d = seg_enc(bcd[3:0]);
            2'd1:    seg_d = (bcd[11:4] == 8'd0) ? SEG_BLANK : seg_enc(bcd[7:4]);
            2'd2:    seg_d = (bcd[11:8] == 4'd0) ? SEG_BLANK : seg_enc(bcd[11:8]);
            default: begin
                seg_d = seg_enc({2'b00, idx_q});
                dp_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
            ptr_q <= '0;
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_q <= '0;
            ptr_q <= ptr_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end else begin
            ref_q <= ref_q + 1'b1;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.dp   = dp_q;
    assign bus.an   = an_q;
    assign bus.busy = busy;
    assign bus.idx  = idx_q;
endmodule

// File: tb/tb_matrix_result_display.sv
// Randomized bench for matrix_result_display; expected digits come from decimal arithmetic on the shown value.
module tb_matrix_result_display;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_result_display_if bus();
    matrix_result_display #(.REFRESH_DIV(4), .SCROLL_DIV(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] SEGS [10];
    int cv [4];

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected {dp, seg} for the lit anode when value v is shown at index ix.
    function automatic int exp_disp(input logic [3:0] a, input int ix, input int v);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (a)
            4'b0111: return {1'b0, SEGS[ix]};
            4'b1011: return {1'b1, (h == 0) ? 7'h7F : SEGS[h]};
            4'b1101: return {1'b1, (v < 10) ? 7'h7F : SEGS[t]};
            4'b1110: return {1'b1, SEGS[o]};
            default: return {1'b1, 7'h7F};
        endcase
    endfunction

    task automatic set_vals(input int a, input int b, input int c, input int d);
        cv[0] = a; cv[1] = b; cv[2] = c; cv[3] = d;
        bus.c00 = 8'(a); bus.c01 = 8'(b); bus.c10 = 8'(c); bus.c11 = 8'(d);
    endtask

    task automatic scan_check(input string tag, input int ix, input int v);
        logic [3:0] prev;
        int run;
        bit seen;
        seen = 0;
        run  = 0;
        prev = bus.an;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk({tag, "_seg"}, {bus.dp, bus.seg}, exp_disp(bus.an, ix, v));
            if (bus.an != prev) begin
                chk({tag, "_order"}, bus.an, {prev[2:0], prev[3]});
                if (seen) chk({tag, "_dwell"}, run, 4);
                seen = 1;
                run  = 1;
            end else begin
                run++;
            end
            prev = bus.an;
        end
    endtask

    task automatic wait_busy(input logic lvl, input int bound, output bit ok);
        ok = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (bus.busy == lvl) begin
                ok = 1;
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n, cur, rises, rise_k, d, v;
        logic prev_b;

        SEGS[0] = 7'h40; SEGS[1] = 7'h79; SEGS[2] = 7'h24; SEGS[3] = 7'h30; SEGS[4] = 7'h19;
        SEGS[5] = 7'h12; SEGS[6] = 7'h02; SEGS[7] = 7'h78; SEGS[8] = 7'h00; SEGS[9] = 7'h10;
        set_vals(98, 0, 0, 0);
        bus.sel = 2'd0;
        bus.auto_mode = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_seg", bus.seg, 7'h7F);
        chk("rst_an", bus.an, 4'hF);
        chk("rst_dp", bus.dp, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_idx", bus.idx, 0);

        // Conversion of 98 straight out of reset
        rst_n = 1'b1;
        wait_busy(1'b1, 5, ok);
        chk("conv_start", ok, 1);
        n = 0;
        while (bus.busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("busy_len", n, 9);
        repeat (12) @(negedge clk);
        chk("conv_idx", bus.idx, 0);
        scan_check("conv", 0, 98);

        // Blanking of leading zeros
        bus.sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            v = (i == 0) ? 255 : (i == 1) ? 7 : 0;
            bus.c01 = 8'(v);
            cv[1] = v;
            repeat (30) @(negedge clk);
            chk("blank_idx", bus.idx, 1);
            scan_check("blank", 1, v);
        end

        // Auto-scroll
        set_vals(1, 2, 3, 4);
        repeat (20) @(negedge clk);
        bus.auto_mode = 1'b1;
        cur = bus.idx;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bus.idx != cur) ok = 1;
        end
        chk("auto_first_step", ok, 1);
        chk("auto_first_idx", bus.idx, (cur + 1) % 4);
        for (int s = 0; s < 8; s++) begin
            cur = bus.idx;
            if (s == 4) set_vals($urandom_range(0, 255), $urandom_range(0, 255),
                                 $urandom_range(0, 255), $urandom_range(0, 255));
            for (int k = 1; k <= 16; k++) begin
                @(negedge clk);
                if (k == 15) begin
                    chk("auto_hold", bus.idx, cur);
                    chk("auto_disp", {bus.dp, bus.seg}, exp_disp(bus.an, cur, cv[cur]));
                end
                if (k == 16) chk("auto_step", bus.idx, (cur + 1) % 4);
            end
        end
        bus.sel = 2'd2;
        bus.auto_mode = 1'b0;
        @(negedge clk);
        chk("manual_return", bus.idx, 2);

        // Change of input while a conversion is in flight
        bus.sel = 2'd0;
        bus.c00 = 8'd98;
        cv[0] = 98;
        repeat (30) @(negedge clk);
        bus.c00 = 8'd5;
        rises = 0;
        rise_k = -10;
        prev_b = bus.busy;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.busy && !prev_b) begin
                rises++;
                if (rises == 1) rise_k = k;
            end
            if (k == rise_k + 2) bus.c00 = 8'd200;
            d = {bus.dp, bus.seg};
            chk("mid_digit", int'(d == exp_disp(bus.an, 0, 98) || d == exp_disp(bus.an, 0, 5) ||
                                  d == exp_disp(bus.an, 0, 200)), 1);
            prev_b = bus.busy;
        end
        chk("mid_conversions", rises, 2);
        cv[0] = 200;
        scan_check("mid", 0, 200);

        // Random manual selections
        for (int i = 0; i < 6; i++) begin
            set_vals($urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 255));
            cur = $urandom_range(0, 3);
            bus.sel = 2'(cur);
            repeat (30) @(negedge clk);
            chk("rand_idx", bus.idx, cur);
            scan_check("rand", cur, cv[cur]);
        end

        // Reset asserted mid-conversion
        bus.sel = 2'd0;
        cv[0] = cv[0] ^ 8'h55;
        bus.c00 = 8'(cv[0]);
        wait_busy(1'b1, 5, ok);
        chk("pre_rst_busy", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", bus.seg, 7'h7F);
        chk("arst_an", bus.an, 4'hF);
        chk("arst_dp", bus.dp, 1);
        chk("arst_busy", bus.busy, 0);
        chk("arst_idx", bus.idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_busy(1'b1, 5, ok);
        chk("post_rst_conv", ok, 1);
        repeat (25) @(negedge clk);
        scan_check("post_rst", 0, cv[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
